register_scoreboard: RTL and testbench

//  Producer-side companion to operand forwarding in the pipelined CPU: records destination

---
 rtl/register_scoreboard.sv | 90 +++++++++
 tb/tb_register_scoreboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
// Register scoreboard for the ID stage. It tracks destination registers whose results cannot be forwarded yet and raises a stall on RAW or WAW hazards against them.
// Optional build macro SCOREBOARD_STATS_EN adds a saturating stall-cycle counter output (stall_cycles_o).
module register_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 3,
  parameter int MAX_LAT  = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic                issue_regwrite_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [CNT_W-1:0]    issue_lat_i,
  input  logic [4:0]          issue_rs_i,
  input  logic [4:0]          issue_rt_i,
  input  logic                issue_use_rt_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] pending_o
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]         stall_cycles_o
`endif
);

  localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);

  // Register 0 is hard-wired zero, so it has no counter.
  logic [CNT_W-1:0]    cnt_reg [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] raw_a_hit;
  logic [NUM_REGS-1:0] raw_b_hit;
  logic [NUM_REGS-1:0] waw_hit;
  logic [NUM_REGS-1:0] wr_sel;
  logic [CNT_W-1:0]    lat_c;
  logic                hazard;
  logic                accept;

  assign lat_c = (issue_lat_i > MAX_LAT_C) ? MAX_LAT_C : issue_lat_i;

  assign raw_a_hit[0] = 1'b0;
  assign raw_b_hit[0] = 1'b0;
  assign waw_hit[0]   = 1'b0;
  assign wr_sel[0]    = 1'b0;
  assign pending_o[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic nz;
      assign nz = (cnt_reg[gi] != '0);

      assign raw_a_hit[gi] = (issue_rs_i == 5'(gi)) && nz;
      assign raw_b_hit[gi] = issue_use_rt_i && (issue_rt_i == 5'(gi)) && nz;
      // An in-flight write that lands after the new one would clobber it.
      assign waw_hit[gi]   = issue_regwrite_i && (issue_rd_i == 5'(gi)) &&
                             (cnt_reg[gi] > lat_c);
      assign wr_sel[gi]    = accept && issue_regwrite_i && (issue_rd_i == 5'(gi));
      assign pending_o[gi] = nz;

      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          cnt_reg[gi] <= '0;
        end else if (wr_sel[gi]) begin
          cnt_reg[gi] <= lat_c;
        end else if (nz) begin
          cnt_reg[gi] <= cnt_reg[gi] - CNT_W'(1);
        end
      end
    end
  endgenerate

  assign hazard  = (|raw_a_hit) || (|raw_b_hit) || (|waw_hit);
  assign stall_o = issue_valid_i && !flush_i && hazard;
  assign accept  = issue_valid_i && !flush_i && !hazard;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cycles_reg <= '0;
    end else if (stall_o && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed scoreboard bench for register_scoreboard: the stimulus queues expected stall/pending per cycle, and a negedge monitor pops and compares.
module tb_register_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        regwrite = 1'b0;
  logic [4:0]  rd = '0;
  logic [2:0]  lat = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic        use_rt = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] pending;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        stall;
    logic [31:0] pend;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  register_scoreboard dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .issue_valid_i    (valid),
    .issue_regwrite_i (regwrite),
    .issue_rd_i       (rd),
    .issue_lat_i      (lat),
    .issue_rs_i       (rs),
    .issue_rt_i       (rt),
    .issue_use_rt_i   (use_rt),
    .flush_i          (flush),
    .stall_o          (stall),
    .pending_o        (pending)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles_o   (stall_cycles)
`endif
  );

  function automatic logic [31:0] bit_of(input int r);
    return 32'd1 << r;
  endfunction

  // Inputs change just after the rising edge. Pending reflects the state that the edge produced.
  task automatic step(input logic r_n, input logic v, input logic rw, input logic [4:0] d,
                      input logic [2:0] l, input logic [4:0] a, input logic [4:0] b,
                      input logic ub, input logic fl, input logic es,
                      input logic [31:0] ep, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r_n; valid = v; regwrite = rw; rd = d; lat = l;
    rs = a; rt = b; use_rt = ub; flush = fl;
    e.stall = es; e.pend = ep; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] ep, input string nm);
    step(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ep, nm);
  endtask

  // Monitor: one line per cycle transaction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compared++;
      if (stall !== e.stall) begin
        mismatched++;
        $display("FAIL %s.stall actual=%0b required=%0b", e.name, stall, e.stall);
      end
      compared++;
      if (pending !== e.pend) begin
        mismatched++;
        $display("FAIL %s.pending actual=%h required=%h", e.name, pending, e.pend);
      end
      $display("txn %s stall=%0b pending=%h", e.name, stall, pending);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles while a valid write request is presented
    valid = 1'b1; regwrite = 1'b1; rd = 5'd8; lat = 3'd3; rs = 5'd8;
    step(1'b0, 1'b1, 1'b1, 5'd8, 3'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "rst_hold0");
    step(1'b0, 1'b1, 1'b1, 5'd8, 3'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "rst_hold1");
    idle(32'd0, "rst_release");

    // Load-use
    step(1'b1, 1'b1, 1'b1, 5'd8, 3'd1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "lu_issue");
    step(1'b1, 1'b1, 1'b1, 5'd9, 3'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, bit_of(8), "lu_stall");
    step(1'b1, 1'b1, 1'b1, 5'd9, 3'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "lu_accept");
    idle(32'd0, "lu_after");

    // Multi-cycle with rt dependency
    step(1'b1, 1'b1, 1'b1, 5'd5, 3'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mc_issue");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, bit_of(5),
           $sformatf("mc_stall%0d", i));
    step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, "mc_accept");
    step(1'b1, 1'b1, 1'b1, 5'd5, 3'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mc_issue2");
    step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, bit_of(5), "mc_nort");
    idle(bit_of(5), "mc_idle0");
    idle(bit_of(5), "mc_idle1");
    idle(bit_of(5), "mc_idle2");
    idle(32'd0, "mc_drain");

    // WAW
    step(1'b1, 1'b1, 1'b1, 5'd3, 3'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "waw_first");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b1, 5'd3, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, bit_of(3),
           $sformatf("waw_stall%0d", i));
    step(1'b1, 1'b1, 1'b1, 5'd3, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, bit_of(3), "waw_accept");
    step(1'b1, 1'b1, 1'b1, 5'd3, 3'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, bit_of(3), "waw_longer");
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, bit_of(3),
           $sformatf("waw_dep%0d", i));
    step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "waw_dep_go");

    // Register zero and flush
    step(1'b1, 1'b1, 1'b1, 5'd0, 3'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "z_rd0");
    step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, "z_src0");
    step(1'b1, 1'b1, 1'b1, 5'd10, 3'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "fl_issue");
    step(1'b1, 1'b1, 1'b1, 5'd11, 3'd2, 5'd10, 5'd0, 1'b0, 1'b1, 1'b0, bit_of(10), "fl_dep");
    idle(bit_of(10), "fl_idle0");
    idle(bit_of(10), "fl_idle1");
    idle(32'd0, "fl_drain");

    // Reset mid-operation
    step(1'b1, 1'b1, 1'b1, 5'd9, 3'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "mr_issue");
    step(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, bit_of(9), "mr_assert");
    idle(32'd0, "mr_cleared");
`ifdef SCOREBOARD_STATS_EN
    @(negedge clk);
    compared++;
    if (stall_cycles !== 32'd0) begin
      mismatched++;
      $display("FAIL stats_reset actual=%0d required=0", stall_cycles);
    end
`endif

    // Maximum latency
    step(1'b1, 1'b1, 1'b1, 5'd20, 3'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "cl_issue");
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd20, 5'd0, 1'b0, 1'b0, 1'b1, bit_of(20),
           $sformatf("cl_stall%0d", i));
    step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 5'd20, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, "cl_accept");
    idle(32'd0, "cl_idle");
`ifdef SCOREBOARD_STATS_EN
    @(negedge clk);
    compared++;
    if (stall_cycles !== 32'd7) begin
      mismatched++;
      $display("FAIL stats_count actual=%0d required=7", stall_cycles);
    end
`endif

    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
